// File: rtl/ppm_pkg.sv
// Shared state encoding and sizing helpers for the PPM stream demodulator.
package ppm_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    GUARD   = 1'b1
  } ppm_state_e;

  function automatic int ppm_slots(input int ppm_bits);
    return 1 << ppm_bits;
  endfunction

  // Keep at least one bit so a zero-guard build still has a legal counter.
  function automatic int ppm_guard_width(input int guard_slots);
    return (guard_slots < 1) ? 1 : $clog2(guard_slots + 1);
  endfunction

endpackage

// File: rtl/ppm_peak_tracker.sv
// Running max/argmax over one PPM frame; outputs are the values including the current chip.
// Optional tie flag is built when PPM_TIE_DETECT_EN is defined.
module ppm_peak_tracker #(
  parameter int CHIP_BITS = 1,
  parameter int PPM_BITS  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 load_i,
  input  logic [PPM_BITS-1:0]  slot_i,
  input  logic [CHIP_BITS-1:0] chip_i,
  output logic [CHIP_BITS-1:0] peak_o,
  output logic [PPM_BITS-1:0]  idx_o
`ifdef PPM_TIE_DETECT_EN
  ,
  output logic                 tie_o
`endif
);

  logic [CHIP_BITS-1:0] best_q, best_d;
  logic [PPM_BITS-1:0]  idx_q, idx_d;

`ifdef PPM_TIE_DETECT_EN
  logic tie_q, tie_d;

  // A tie is remembered until a strictly larger chip takes over the peak.
  always_comb begin
    best_d = best_q;
    idx_d  = idx_q;
    tie_d  = tie_q;
    if (load_i) begin
      best_d = chip_i;
      idx_d  = '0;
      tie_d  = 1'b0;
    end else if (chip_i > best_q) begin
      best_d = chip_i;
      idx_d  = slot_i;
      tie_d  = 1'b0;
    end else if (chip_i == best_q) begin
      tie_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tie_q <= 1'b0;
    end else if (en_i) begin
      tie_q <= tie_d;
    end
  end

  assign tie_o = tie_d;
`else
  always_comb begin
    best_d = best_q;
    idx_d  = idx_q;
    if (load_i) begin
      best_d = chip_i;
      idx_d  = '0;
    end else if (chip_i > best_q) begin
      best_d = chip_i;
      idx_d  = slot_i;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      best_q <= '0;
      idx_q  <= '0;
    end else if (en_i) begin
      best_q <= best_d;
      idx_q  <= idx_d;
    end
  end

  assign peak_o = best_d;
  assign idx_o  = idx_d;

endmodule

// File: rtl/ppm_stream_demod.sv
// Serial M-ary PPM demodulator: frame FSM, guard skipping, resync and valid/ready symbol output.
// Define PPM_TIE_DETECT_EN to add the peak_tie output.
module ppm_stream_demod
  import ppm_pkg::*;
#(
  parameter int CHIP_BITS   = 1,
  parameter int PPM_BITS    = 3,
  parameter int GUARD_SLOTS = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CHIP_BITS-1:0] chip_in,
  input  logic                 chip_valid,
  output logic                 chip_ready,
  input  logic                 frame_sync,
  input  logic [CHIP_BITS-1:0] corr_threshold,
  output logic [PPM_BITS-1:0]  symbol,
  output logic [CHIP_BITS-1:0] peak_value,
  output logic                 threshold_unmet,
  output logic                 sym_valid,
  input  logic                 sym_ready
`ifdef PPM_TIE_DETECT_EN
  ,
  output logic                 peak_tie
`endif
);

  localparam int M  = ppm_slots(PPM_BITS);
  localparam int GW = ppm_guard_width(GUARD_SLOTS);
  localparam logic [PPM_BITS-1:0] LAST_SLOT  = PPM_BITS'(M - 1);
  localparam logic [GW-1:0]       GUARD_LAST = GW'((GUARD_SLOTS > 0) ? GUARD_SLOTS - 1 : 0);
  localparam ppm_state_e          AFTER_FRAME = (GUARD_SLOTS > 0) ? GUARD : COLLECT;

  ppm_state_e           state_q;
  logic [PPM_BITS-1:0]  slot_q;
  logic [GW-1:0]        guard_q;
  logic [PPM_BITS-1:0]  symbol_q;
  logic [CHIP_BITS-1:0] peak_q;
  logic                 unmet_q;
  logic                 valid_q;

  logic                 at_last;
  logic                 accept;
  logic                 track_load;
  logic                 track_en;
  logic                 emit;
  logic [CHIP_BITS-1:0] peak_d;
  logic [PPM_BITS-1:0]  idx_d;

  // Only the last slot can stall: it is the one that would overwrite a pending symbol.
  assign at_last    = (state_q == COLLECT) && (slot_q == LAST_SLOT);
  assign chip_ready = !(at_last && valid_q && !sym_ready);
  assign accept     = chip_valid && chip_ready;
  assign track_load = frame_sync || ((state_q == COLLECT) && (slot_q == '0));
  assign track_en   = accept && (frame_sync || (state_q == COLLECT));
  assign emit       = accept && !frame_sync && at_last;

`ifdef PPM_TIE_DETECT_EN
  logic tie_d;
  logic tie_q;

  ppm_peak_tracker #(
    .CHIP_BITS(CHIP_BITS),
    .PPM_BITS (PPM_BITS)
  ) u_tracker (
    .clk   (clk),
    .rst   (rst),
    .en_i  (track_en),
    .load_i(track_load),
    .slot_i(slot_q),
    .chip_i(chip_in),
    .peak_o(peak_d),
    .idx_o (idx_d),
    .tie_o (tie_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tie_q <= 1'b0;
    end else if (emit) begin
      tie_q <= tie_d;
    end
  end

  assign peak_tie = tie_q;
`else
  ppm_peak_tracker #(
    .CHIP_BITS(CHIP_BITS),
    .PPM_BITS (PPM_BITS)
  ) u_tracker (
    .clk   (clk),
    .rst   (rst),
    .en_i  (track_en),
    .load_i(track_load),
    .slot_i(slot_q),
    .chip_i(chip_in),
    .peak_o(peak_d),
    .idx_o (idx_d)
  );
`endif

  // frame_sync wins over every slot/guard position and restarts the frame at slot 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= COLLECT;
      slot_q   <= '0;
      guard_q  <= '0;
      symbol_q <= '0;
      peak_q   <= '0;
      unmet_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      if (accept) begin
        if (frame_sync) begin
          state_q <= COLLECT;
          slot_q  <= PPM_BITS'(1);
          guard_q <= '0;
        end else if (state_q == COLLECT) begin
          if (at_last) begin
            state_q <= AFTER_FRAME;
            slot_q  <= '0;
            guard_q <= '0;
          end else begin
            slot_q <= slot_q + 1'b1;
          end
        end else if (guard_q == GUARD_LAST) begin
          state_q <= COLLECT;
          guard_q <= '0;
        end else begin
          guard_q <= guard_q + 1'b1;
        end
      end

      if (emit) begin
        symbol_q <= idx_d;
        peak_q   <= peak_d;
        unmet_q  <= (peak_d < corr_threshold);
        valid_q  <= 1'b1;
      end else if (valid_q && sym_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign symbol          = symbol_q;
  assign peak_value      = peak_q;
  assign threshold_unmet = unmet_q;
  assign sym_valid       = valid_q;

endmodule

// File: tb/tb_ppm_stream_demod.sv
// Directed bench for ppm_stream_demod: table of whole frames plus backpressure, resync, reset and guard sequences.
module tb_ppm_stream_demod;

  typedef struct {
    logic [31:0] chips;
    logic [3:0]  thr;
    logic [2:0]  expSym;
    logic [3:0]  expPeak;
    logic        expUnmet;
    logic        expTie;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] chipIn;
  logic       chipValid;
  logic       chipReady;
  logic       frameSync;
  logic [3:0] corrThreshold;
  logic [2:0] symbol;
  logic [3:0] peakValue;
  logic       thresholdUnmet;
  logic       symValid;
  logic       symReady;

  logic [3:0] gChipIn;
  logic       gChipValid;
  logic       gChipReady;
  logic [2:0] gSymbol;
  logic [3:0] gPeakValue;
  logic       gThresholdUnmet;
  logic       gSymValid;

`ifdef PPM_TIE_DETECT_EN
  logic peakTie;
  logic gPeakTie;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ppm_stream_demod #(.CHIP_BITS(4), .PPM_BITS(3), .GUARD_SLOTS(0)) dut (
    .clk            (clk),
    .rst            (rst),
    .chip_in        (chipIn),
    .chip_valid     (chipValid),
    .chip_ready     (chipReady),
    .frame_sync     (frameSync),
    .corr_threshold (corrThreshold),
    .symbol         (symbol),
    .peak_value     (peakValue),
    .threshold_unmet(thresholdUnmet),
    .sym_valid      (symValid),
    .sym_ready      (symReady)
`ifdef PPM_TIE_DETECT_EN
    ,
    .peak_tie       (peakTie)
`endif
  );

  ppm_stream_demod #(.CHIP_BITS(4), .PPM_BITS(3), .GUARD_SLOTS(2)) dutGuard (
    .clk            (clk),
    .rst            (rst),
    .chip_in        (gChipIn),
    .chip_valid     (gChipValid),
    .chip_ready     (gChipReady),
    .frame_sync     (1'b0),
    .corr_threshold (4'd5),
    .symbol         (gSymbol),
    .peak_value     (gPeakValue),
    .threshold_unmet(gThresholdUnmet),
    .sym_valid      (gSymValid),
    .sym_ready      (1'b1)
`ifdef PPM_TIE_DETECT_EN
    ,
    .peak_tie       (gPeakTie)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] chip, input logic sync);
    @(negedge clk);
    chipIn    = chip;
    chipValid = 1'b1;
    frameSync = sync;
  endtask

  task automatic applyIdle();
    @(negedge clk);
    chipValid = 1'b0;
    frameSync = 1'b0;
    chipIn    = 4'd0;
  endtask

  // Slot i of the frame is nibble i counting from the most significant end.
  task automatic applyFrame(input logic [31:0] word);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(word[31-4*i -: 4], 1'b0);
    end
    applyIdle();
  endtask

  vec_t vecs[7];
  logic [3:0] syncChips[12];
  logic [3:0] guardChips[20];
  logic       sawValid;
  int         gotCount;
  logic [2:0] gotSym[4];
  logic [3:0] gotPeak[4];

  initial begin
    vecs[0] = '{32'h01000902, 4'd3,  3'd5, 4'd9,  1'b0, 1'b0};
    vecs[1] = '{32'h27710000, 4'd8,  3'd1, 4'd7,  1'b1, 1'b1};
    vecs[2] = '{32'h44444444, 4'd4,  3'd0, 4'd4,  1'b0, 1'b1};
    vecs[3] = '{32'h0000000F, 4'd15, 3'd7, 4'd15, 1'b0, 1'b0};
    vecs[4] = '{32'h00000000, 4'd1,  3'd0, 4'd0,  1'b1, 1'b1};
    vecs[5] = '{32'h33512044, 4'd0,  3'd2, 4'd5,  1'b0, 1'b0};
    vecs[6] = '{32'hFE000000, 4'd0,  3'd0, 4'd15, 1'b0, 1'b0};
    syncChips  = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd2, 4'd0, 4'd0, 4'd9, 4'd0, 4'd0, 4'd0, 4'd1};
    guardChips = '{4'd1, 4'd0, 4'd0, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0, 4'd15, 4'd15,
                   4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd9, 4'd0, 4'd15, 4'd15};

    rst = 1'b1;
    chipIn = 4'd0;
    chipValid = 1'b0;
    frameSync = 1'b0;
    corrThreshold = 4'd0;
    symReady = 1'b1;
    gChipIn = 4'd0;
    gChipValid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset symbol", 32'(symbol), 32'd0);
    checkOutput("reset peak", 32'(peakValue), 32'd0);
    checkOutput("reset unmet", 32'(thresholdUnmet), 32'd0);
    checkOutput("reset valid", 32'(symValid), 32'd0);
    checkOutput("reset chip_ready", 32'(chipReady), 32'd1);
    rst = 1'b0;

    // Guard build: 20 back-to-back chips, guard chips carry 15 to expose any leak.
    gotCount = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (gSymValid) begin
        if (gotCount < 4) begin
          gotSym[gotCount]  = gSymbol;
          gotPeak[gotCount] = gPeakValue;
        end
        gotCount++;
      end
      gChipValid = (i < 20);
      gChipIn    = (i < 20) ? guardChips[i] : 4'd0;
    end
    checkOutput("guard symbol count", 32'(gotCount), 32'd2);
    checkOutput("guard sym0", 32'(gotSym[0]), 32'd3);
    checkOutput("guard peak0", 32'(gotPeak[0]), 32'd8);
    checkOutput("guard sym1", 32'(gotSym[1]), 32'd6);
    checkOutput("guard peak1", 32'(gotPeak[1]), 32'd9);

    for (int v = 0; v < 7; v++) begin
      corrThreshold = vecs[v].thr;
      applyFrame(vecs[v].chips);
      checkOutput($sformatf("vec%0d valid", v), 32'(symValid), 32'd1);
      checkOutput($sformatf("vec%0d symbol", v), 32'(symbol), 32'(vecs[v].expSym));
      checkOutput($sformatf("vec%0d peak", v), 32'(peakValue), 32'(vecs[v].expPeak));
      checkOutput($sformatf("vec%0d unmet", v), 32'(thresholdUnmet), 32'(vecs[v].expUnmet));
`ifdef PPM_TIE_DETECT_EN
      checkOutput($sformatf("vec%0d tie", v), 32'(peakTie), 32'(vecs[v].expTie));
`endif
      @(negedge clk);
      checkOutput($sformatf("vec%0d valid drop", v), 32'(symValid), 32'd0);
    end

    // Backpressure: second frame stalls on slot 7 until the first symbol is taken.
    symReady = 1'b0;
    corrThreshold = 4'd3;
    applyFrame(vecs[0].chips);
    checkOutput("bp first valid", 32'(symValid), 32'd1);
    corrThreshold = 4'd8;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[1].chips[31-4*i -: 4], 1'b0);
    end
    #1;
    checkOutput("bp stall ready", 32'(chipReady), 32'd0);
    @(negedge clk);
    checkOutput("bp still stalled", 32'(chipReady), 32'd0);
    checkOutput("bp hold valid", 32'(symValid), 32'd1);
    checkOutput("bp hold symbol", 32'(symbol), 32'd5);
    checkOutput("bp hold peak", 32'(peakValue), 32'd9);
    symReady = 1'b1;
    #1;
    checkOutput("bp release ready", 32'(chipReady), 32'd1);
    applyIdle();
    checkOutput("bp second valid", 32'(symValid), 32'd1);
    checkOutput("bp second symbol", 32'(symbol), 32'd1);
    checkOutput("bp second peak", 32'(peakValue), 32'd7);
    checkOutput("bp second unmet", 32'(thresholdUnmet), 32'd1);
    @(negedge clk);
    checkOutput("bp no duplicate", 32'(symValid), 32'd0);

    // Resync on the 5th chip drops the four 15s before it.
    corrThreshold = 4'd10;
    sawValid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(syncChips[i], (i == 4));
      sawValid = sawValid | symValid;
    end
    applyIdle();
    checkOutput("sync no early symbol", 32'(sawValid), 32'd0);
    checkOutput("sync valid", 32'(symValid), 32'd1);
    checkOutput("sync symbol", 32'(symbol), 32'd3);
    checkOutput("sync peak", 32'(peakValue), 32'd9);
    checkOutput("sync unmet", 32'(thresholdUnmet), 32'd1);

    // Reset mid-frame while a symbol is pending.
    symReady = 1'b0;
    corrThreshold = 4'd3;
    applyFrame(vecs[0].chips);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'd1, 1'b0);
    end
    applyStimulus(4'd1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst symbol", 32'(symbol), 32'd0);
    checkOutput("rst peak", 32'(peakValue), 32'd0);
    checkOutput("rst unmet", 32'(thresholdUnmet), 32'd0);
    checkOutput("rst valid", 32'(symValid), 32'd0);
`ifdef PPM_TIE_DETECT_EN
    checkOutput("rst tie", 32'(peakTie), 32'd0);
`endif
    rst = 1'b0;
    chipValid = 1'b0;
    symReady = 1'b1;
    corrThreshold = vecs[5].thr;
    applyFrame(vecs[5].chips);
    checkOutput("post rst valid", 32'(symValid), 32'd1);
    checkOutput("post rst symbol", 32'(symbol), 32'd2);
    checkOutput("post rst peak", 32'(peakValue), 32'd5);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ppm_stream_demod.md
Name: ppm_stream_demod

Overview:
Serial M-ary PPM demodulator, the parametrised successor to the 8-slot combinational correlator. It takes one chip per cycle from the SPAD front-end and finds the peak slot over each frame of M = 2^PPM_BITS slots. Each completed frame produces one symbol on a valid/ready output with threshold check and peak value. It adds configurable guard slots between frames, frame resync, and output backpressure.

Parameters:
CHIP_BITS, 1, bits per chip (unsigned magnitude)
PPM_BITS, 3, bits per symbol; M = 2^PPM_BITS slots per frame; legal range 1..8
GUARD_SLOTS, 0, chips discarded after each frame's last slot; legal range 0..255

Ports:
clk  in  1  single clock; all logic rising-edge
rst  in  1  synchronous, active-high reset
chip_in  in  CHIP_BITS  current chip magnitude
chip_valid  in  1  chip_in is valid this cycle
chip_ready  out  1  block accepts chip this cycle; accept = chip_valid & chip_ready
frame_sync  in  1  qualified by accept; the accepted chip is slot 0 of a new frame
corr_threshold  in  CHIP_BITS  minimum peak; sampled on the last-slot accept
symbol  out  PPM_BITS  index of the peak slot
peak_value  out  CHIP_BITS  magnitude of the peak slot
threshold_unmet  out  1  peak_value < sampled threshold
sym_valid  out  1  output registers hold an unconsumed symbol
sym_ready  in  1  downstream consumes; transfer = sym_valid & sym_ready

Behaviour:
- Reset: symbol=0, peak_value=0, threshold_unmet=0, sym_valid=0. State is COLLECT with slot=0, best value and best index cleared, guard count 0. rst has priority over every other input.
- States:
  - COLLECT: slot counter runs 0..M-1.
  - GUARD: guard counter runs 0..GUARD_SLOTS-1.
- COLLECT, accept at slot 0: best value and best index load unconditionally (best := chip_in, idx := 0).
- COLLECT, accept at slot k > 0: update only if chip_in > best (strict). Ties keep the lower index.
- COLLECT, accept at slot M-1:
  - Compute the final peak including this chip. Register symbol, peak_value, and threshold_unmet = peak < corr_threshold. Set sym_valid=1.
  - Output latency is 1 cycle after the last-slot accept.
  - Next state is GUARD if GUARD_SLOTS > 0, else COLLECT slot 0.
- GUARD: each accepted chip is discarded and increments the guard counter. After the GUARD_SLOTS-th accept, go to COLLECT slot 0.
- Cycles without accept: no state change.
- chip_ready = !(state==COLLECT && slot==M-1 && sym_valid && !sym_ready).
  - It stalls only when the last slot would overwrite an unconsumed symbol. This is combinational from sym_ready.
- Simultaneous transfer and last-slot accept: the new symbol loads and sym_valid stays 1.
- Transfer with no new symbol: sym_valid falls next cycle. Outputs stay stable while sym_valid & !sym_ready.
- frame_sync on accept, in any state or slot:
  - The partial frame is discarded with no output, and any guard count is cleared.
  - The chip becomes slot 0 and the state becomes COLLECT at slot 1, or goes straight to output if M==1 is ever allowed (it is not; PPM_BITS >= 1).
- frame_sync while chip_ready=0 has no effect; the stall rule still holds.
- frame_sync without chip_valid is ignored.
- Slot and guard counters wrap only by the explicit transitions above; no free-running overflow.
- All comparisons are unsigned CHIP_BITS wide.

Optional Feature:
- Macro: PPM_TIE_DETECT_EN.
- Defined: extra output port peak_tie (1 bit).
  - Registered with symbol; reset 0.
  - High when some slot other than the reported index equals the final peak value. A tie is tracked as: set when chip_in == best at k > 0; cleared when a strictly larger chip arrives.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package ppm_pkg holds:
  - state encoding (COLLECT, GUARD);
  - the localparam function for M from PPM_BITS;
  - the counter-width helper (clog2 of GUARD_SLOTS+1).
- One sub-module, ppm_peak_tracker:
  - running max/argmax with a load-on-slot-0 input and strict-greater update;
  - the tie flag under PPM_TIE_DETECT_EN.
- The top level owns the FSM, counters, handshake and output register.

Test Plan:
- CHIP_BITS=4, PPM_BITS=3, GUARD_SLOTS=0, threshold 3, sym_ready=1: chips 0,1,0,0,0,9,0,2 -> symbol=5, peak_value=9, threshold_unmet=0, sym_valid for exactly 1 cycle, one cycle after the 8th accept.
- Same config, chips 2,7,7,1,0,0,0,0 with threshold 8 -> symbol=1, peak_value=7, threshold_unmet=1. With PPM_TIE_DETECT_EN: peak_tie=1.
- GUARD_SLOTS=2, 20 chips back-to-back, two frames with peaks at slot 3 then slot 6 -> symbols 3 then 6. The 2 chips after each frame do not affect the next symbol.
- sym_ready=0 after the first symbol: feed a second full frame -> chip_ready falls at slot 7 and the first symbol holds. Raise sym_ready -> slot-7 chip accepted in that same cycle, second symbol appears next cycle, no symbol lost or duplicated.
- frame_sync asserted on the 5th chip of a frame: the previous 4 chips are dropped and no symbol is emitted. The following 8 chips (including the synced one) yield a symbol matching their own peak.
- rst asserted mid-frame (slot 4) while sym_valid=1 -> next cycle all outputs 0 and sym_valid=0. A fresh 8-chip frame then decodes correctly.
